// File: rtl/hazard_ctrl_seq.sv
// Sequential hazard controller for a five-stage RISC-V pipeline: load-use bubbles,
// variable-latency EX stalls, programmable branch flush, dmem freeze and a stall counter.
module hazard_ctrl_seq #(
    parameter int REG_W     = 5,
    parameter int NSTAGE    = 4,
    parameter int MUL_LAT   = 3,
    parameter int FLUSH_CYC = 1,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       instr,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic              ex_memread,
    input  logic              ex_mul,
    input  logic              branch_taken,
    input  logic              imem_wait,
    input  logic              dmem_wait,
    output logic              en_pc,
    output logic [NSTAGE-1:0] en_stage,
    output logic [NSTAGE-1:0] clr,
    output logic              ctr_mux,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    // Counters hold "MUL/FLUSH cycles still to spend", so they never exceed LAT-2 / CYC-1.
    localparam int MCW = (MUL_LAT > 4) ? $clog2(MUL_LAT) : 2;
    localparam int FCW = (FLUSH_CYC > 4) ? $clog2(FLUSH_CYC) : 2;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_MUL   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [MCW-1:0]     mcnt_r;
    logic [MCW-1:0]     mcnt_nxt_s;
    logic [FCW-1:0]     fcnt_r;
    logic [FCW-1:0]     fcnt_nxt_s;
    logic [CNT_W-1:0]   stall_cnt_r;

    logic [REG_W-1:0]   rs1_s;
    logic [REG_W-1:0]   rs2_s;
    logic               use_rs1_s;
    logic               use_rs2_s;
    logic               lu_hit_s;
    logic               en_pc_s;
    logic [NSTAGE-1:0]  hold_s;
    logic [NSTAGE-1:0]  clr_s;
    logic               ctr_mux_s;
    logic               unused_s;

    assign rs1_s    = REG_W'(instr[19:15]);
    assign rs2_s    = REG_W'(instr[24:20]);
    assign unused_s = ^{instr[31:25], instr[14:7]};

    // Source-operand decode and load-use hit detection (x0 never creates a hazard).
    always_comb begin
        use_rs1_s = 1'b0;
        use_rs2_s = 1'b0;
        case (instr[6:0])
            OP_LUI, OP_AUIPC, OP_JAL: begin
                use_rs1_s = 1'b0;
                use_rs2_s = 1'b0;
            end
            OP_JALR, OP_LOAD, OP_IMM: begin
                use_rs1_s = 1'b1;
                use_rs2_s = 1'b0;
            end
            OP_STORE, OP_BRANCH, OP_OP: begin
                use_rs1_s = 1'b1;
                use_rs2_s = 1'b1;
            end
            default: begin
                use_rs1_s = 1'b0;
                use_rs2_s = 1'b0;
            end
        endcase
        lu_hit_s = ex_memread && (ex_rd != {REG_W{1'b0}}) &&
                   ((use_rs1_s && (ex_rd == rs1_s)) || (use_rs2_s && (ex_rd == rs2_s)));
    end

    // Hazard priority resolution and next-state computation.
    always_comb begin
        en_pc_s     = 1'b1;
        hold_s      = {NSTAGE{1'b1}};
        clr_s       = {NSTAGE{1'b0}};
        ctr_mux_s   = 1'b0;
        state_nxt_s = state_r;
        mcnt_nxt_s  = mcnt_r;
        fcnt_nxt_s  = fcnt_r;
        case (state_r)
            ST_RUN: begin
                if (dmem_wait) begin
                    en_pc_s = 1'b0;
                    hold_s  = {NSTAGE{1'b0}};
                end else if (branch_taken) begin
                    clr_s[1:0] = 2'b11;
                    if (FLUSH_CYC > 1) begin
                        state_nxt_s = ST_FLUSH;
                        fcnt_nxt_s  = FCW'(FLUSH_CYC - 1);
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end else if (ex_mul && (MUL_LAT > 1)) begin
                    en_pc_s     = 1'b0;
                    hold_s[1:0] = 2'b00;
                    clr_s[2]    = 1'b1;
                    if (MUL_LAT > 2) begin
                        state_nxt_s = ST_MUL;
                        mcnt_nxt_s  = MCW'(MUL_LAT - 2);
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end else if (lu_hit_s) begin
                    en_pc_s   = 1'b0;
                    hold_s[0] = 1'b0;
                    clr_s[1]  = 1'b1;
                    ctr_mux_s = 1'b1;
                end else if (imem_wait) begin
                    en_pc_s  = 1'b0;
                    clr_s[0] = 1'b1;
                end else begin
                    en_pc_s = 1'b1;
                end
            end
            ST_MUL: begin
                en_pc_s = 1'b0;
                if (dmem_wait) begin
                    hold_s = {NSTAGE{1'b0}};
                end else begin
                    hold_s[1:0] = 2'b00;
                    clr_s[2]    = 1'b1;
                end
                // The EX unit keeps counting while memory is frozen.
                if (mcnt_r <= MCW'(1)) begin
                    state_nxt_s = ST_RUN;
                    mcnt_nxt_s  = {MCW{1'b0}};
                end else begin
                    mcnt_nxt_s = mcnt_r - MCW'(1);
                end
            end
            ST_FLUSH: begin
                if (dmem_wait) begin
                    en_pc_s = 1'b0;
                    hold_s  = {NSTAGE{1'b0}};
                end else begin
                    clr_s[0] = 1'b1;
                    en_pc_s  = !imem_wait;
                    if (fcnt_r <= FCW'(1)) begin
                        state_nxt_s = ST_RUN;
                        fcnt_nxt_s  = {FCW{1'b0}};
                    end else begin
                        fcnt_nxt_s = fcnt_r - FCW'(1);
                    end
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
                mcnt_nxt_s  = {MCW{1'b0}};
                fcnt_nxt_s  = {FCW{1'b0}};
            end
        endcase
    end

    // State, latency counters and saturating stall counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_RUN;
            mcnt_r      <= {MCW{1'b0}};
            fcnt_r      <= {FCW{1'b0}};
            stall_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            mcnt_r  <= mcnt_nxt_s;
            fcnt_r  <= fcnt_nxt_s;
            if (!en_pc_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + CNT_W'(1);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    // Output drive; a clear also enables its stage so the bubble is captured.
    always_comb begin
        if (!rst_n) begin
            en_pc    = 1'b1;
            en_stage = {NSTAGE{1'b1}};
            clr      = {NSTAGE{1'b0}};
            ctr_mux  = 1'b0;
        end else begin
            en_pc    = en_pc_s;
            en_stage = hold_s | clr_s;
            clr      = clr_s;
            ctr_mux  = ctr_mux_s;
        end
        stall_cnt = stall_cnt_r;
    end

endmodule
